// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel refclk divider.
package clkdiv_pkg;
  localparam int DEFAULT_DIV = 16;
  localparam int LOCK_CYCLES = 64;
  localparam int CH_W        = 3;
endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: div/phase/cnt registers and registered output decode.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             outclk,
  output logic             tick
);
  logic [DIV_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
  logic             outclk_q, outclk_d, tick_q, tick_d;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (wr_en) begin
      div_d   = wr_div;
      phase_d = wr_phase;
    end
    // A restart uses the freshly written values so a cfg takes effect at once.
    if (restart)
      cnt_d = (phase_d < div_d) ? phase_d : '0;
    else if (div_q < DIV_W'(2) || cnt_q >= div_q - DIV_W'(1))
      cnt_d = '0;
    else
      cnt_d = cnt_q + DIV_W'(1);

    // Decode the next count so the registered outputs line up with cnt_q.
    if (div_d == '0) begin
      outclk_d = 1'b0;
      tick_d   = 1'b0;
    end else if (div_d == DIV_W'(1)) begin
      outclk_d = 1'b1;
      tick_d   = 1'b1;
    end else begin
      outclk_d = cnt_d < (div_d >> 1);
      tick_d   = cnt_d == '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      div_q    <= DIV_W'(DEF_DIV);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign outclk = outclk_q;
  assign tick   = tick_q;
endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: config decode, sync fan-out and lock counter.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CLK     = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV,
  parameter int LOCK_CYCLES = clkdiv_pkg::LOCK_CYCLES
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DIV_W-1:0]   cfg_phase,
  output logic               cfg_err,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] tick,
  output logic               locked
);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic              run_q, run_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic              cfg_err_q, cfg_err_d;
  logic              ch_ok, accept, hit, restart_all;
  logic [NUM_CLK-1:0] restart, wr_en;

  assign cfg_ready = rst;

  always_comb begin
    ch_ok       = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CLK);
    accept      = cfg_valid && cfg_ready;
    hit         = accept && ch_ok;
    // The first edge out of reset restarts every channel from its phase.
    restart_all = sync || !run_q;
    for (int i = 0; i < NUM_CLK; i++) begin
      wr_en[i]   = hit && (cfg_ch == CH_W'(i));
      restart[i] = restart_all || wr_en[i];
    end
    run_d = 1'b1;
    if (sync || hit)
      lock_cnt_d = LOCK_W'(LOCK_CYCLES);
    else if (lock_cnt_q != '0)
      lock_cnt_d = lock_cnt_q - LOCK_W'(1);
    else
      lock_cnt_d = '0;
    locked_d  = lock_cnt_d == '0;
    cfg_err_d = accept && !ch_ok;
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      run_q      <= 1'b0;
      lock_cnt_q <= LOCK_W'(LOCK_CYCLES);
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign locked  = locked_q;
  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
    clkdiv_chan #(.DIV_W(DIV_W), .DEF_DIV(DEFAULT_DIV)) u_chan (
      .refclk   (refclk),
      .rst      (rst),
      .restart  (restart[g]),
      .wr_en    (wr_en[g]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .outclk   (outclk[g]),
      .tick     (tick[g])
    );
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: vector table, directed corner sequences, random vs model.
module tb_clkdiv_multi;
  localparam int NUM_CLK = 4;
  localparam int DIV_W   = 16;
  localparam int LOCK    = 64;

  logic               refclk = 1'b0;
  logic               rst = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
  logic [2:0]         cfg_ch = '0;
  logic [DIV_W-1:0]   cfg_div = '0, cfg_phase = '0;
  logic               cfg_ready, cfg_err, locked;
  logic [NUM_CLK-1:0] outclk, tick;

  always #5 refclk = ~refclk;

  clkdiv_multi #(.NUM_CLK(NUM_CLK), .DIV_W(DIV_W), .DEFAULT_DIV(16), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk), .rst(rst), .sync(sync), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .outclk(outclk), .tick(tick), .locked(locked)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: each channel counts as (start + cycles since restart) mod div.
  int m_div[NUM_CLK], m_phase[NUM_CLK], m_start[NUM_CLK], m_t0[NUM_CLK];
  int t = 0, t_reload = 0;
  bit m_in_rst = 1'b1, m_err = 1'b0;

  task automatic model_edge();
    bit hit;
    t++;
    if (!rst) begin
      m_in_rst = 1'b1;
      m_err    = 1'b0;
      for (int i = 0; i < NUM_CLK; i++) begin m_div[i] = 16; m_phase[i] = 0; end
    end else begin
      hit   = cfg_valid && (int'(cfg_ch) < NUM_CLK);
      m_err = cfg_valid && (int'(cfg_ch) >= NUM_CLK);
      for (int i = 0; i < NUM_CLK; i++) begin
        bit mine;
        mine = hit && (int'(cfg_ch) == i);
        if (mine) begin m_div[i] = int'(cfg_div); m_phase[i] = int'(cfg_phase); end
        if (m_in_rst || sync || mine) begin
          m_start[i] = (m_phase[i] < m_div[i]) ? m_phase[i] : 0;
          m_t0[i]    = t;
        end
      end
      if (m_in_rst) t_reload = t - 1;
      if (sync || hit) t_reload = t;
      m_in_rst = 1'b0;
    end
  endtask

  task automatic model_out(output logic [NUM_CLK-1:0] eo, output logic [NUM_CLK-1:0] ek,
                           output logic el, output logic ee);
    eo = '0; ek = '0; el = 1'b0; ee = 1'b0;
    if (!m_in_rst) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        int c;
        if (m_div[i] == 1) begin eo[i] = 1'b1; ek[i] = 1'b1; end
        else if (m_div[i] >= 2) begin
          c = (m_start[i] + t - m_t0[i]) % m_div[i];
          eo[i] = c < m_div[i] / 2;
          ek[i] = c == 0;
        end
      end
      el = (t - t_reload) >= LOCK;
      ee = m_err;
    end
  endtask

  task automatic step();
    logic [NUM_CLK-1:0] eo, ek;
    logic el, ee;
    @(posedge refclk);
    model_edge();
    #1;
    model_out(eo, ek, el, ee);
    chk("model", {cfg_ready, cfg_err, locked, tick, outclk}, {rst, ee, el, ek, eo});
  endtask

  typedef struct {
    bit rst, sync, vld;
    logic [2:0] ch;
    int div, ph;
    logic [3:0] eo, ek;
    bit el, ee;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int hi, first_lock, co;
    logic p0, p2;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 4'b1110, 4'b0000, 0, 0};
    tbl[3] = '{1, 0, 1, 1, 1, 0, 4'b1110, 4'b0010, 0, 0};
    tbl[4] = '{1, 0, 1, 7, 9, 9, 4'b1110, 4'b0010, 0, 1};
    tbl[5] = '{1, 0, 1, 2, 3, 5, 4'b1110, 4'b0110, 0, 0};
    tbl[6] = '{1, 0, 0, 0, 0, 0, 4'b1010, 4'b0010, 0, 0};
    tbl[7] = '{1, 1, 0, 0, 0, 0, 4'b1110, 4'b1110, 0, 0};
    tbl[8] = '{0, 0, 1, 3, 2, 0, 4'b0000, 4'b0000, 0, 0};
    foreach (tbl[r]) begin
      rst = tbl[r].rst; sync = tbl[r].sync; cfg_valid = tbl[r].vld; cfg_ch = tbl[r].ch;
      cfg_div = DIV_W'(tbl[r].div); cfg_phase = DIV_W'(tbl[r].ph);
      step();
      chk($sformatf("tbl%0d", r), {cfg_err, locked, tick, outclk},
          {tbl[r].ee, tbl[r].el, tbl[r].ek, tbl[r].eo});
    end
    sync = 0; cfg_valid = 0;

    // Defaults after release: 16-cycle period, 8 high, lock after 64 edges.
    step();
    rst = 1; hi = 0; first_lock = -1;
    for (int e = 1; e <= 200; e++) begin
      step();
      if (e <= 32 && outclk[0]) hi++;
      if (e == 16) chk("A_low16", outclk[0], 0);
      if (e == 17) chk("A_rise17", outclk[0], 1);
      if (locked && first_lock < 0) first_lock = e;
      if (first_lock >= 0) break;
    end
    chk("A_high", hi, 16);
    chk("A_lock", first_lock, 64);

    // ch1 div 5 phase 2.
    cfg_valid = 1; cfg_ch = 1; cfg_div = 5; cfg_phase = 2;
    step();
    cfg_valid = 0;
    chk("B_locked_drop", locked, 0);
    chk("B_start", {outclk[1], tick[1]}, 0);
    hi = 0; first_lock = -1;
    for (int e = 1; e <= 200; e++) begin
      step();
      if (e < 3) chk("B_notick", tick[1], 0);
      if (e == 3) chk("B_tick3", tick[1], 1);
      if (e >= 3 && e <= 7 && outclk[1]) hi++;
      if (locked && first_lock < 0) first_lock = e;
      if (first_lock >= 0) break;
    end
    chk("B_high", hi, 2);
    chk("B_lock", first_lock, 64);

    // Out-of-range channel while locked.
    cfg_valid = 1; cfg_ch = 7; cfg_div = 3; cfg_phase = 0;
    step();
    cfg_valid = 0;
    chk("C_err", cfg_err, 1);
    chk("C_locked", locked, 1);
    step();
    chk("C_err_clr", cfg_err, 0);

    // Aligned ch0 div 4 and ch2 div 6 after sync.
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4; cfg_phase = 0;
    step();
    cfg_ch = 2; cfg_div = 6;
    step();
    cfg_valid = 0; sync = 1;
    step();
    sync = 0; p0 = outclk[0]; p2 = outclk[2]; co = 0;
    for (int e = 1; e <= 36; e++) begin
      step();
      if (outclk[0] && !p0 && outclk[2] && !p2) co++;
      if (e == 12) chk("D_rise12", {outclk[0], p0, outclk[2], p2}, 4'b1010);
      p0 = outclk[0]; p2 = outclk[2];
    end
    chk("D_coincide", co, 3);

    // Reset mid-period and mid-lock.
    repeat (5) step();
    rst = 0;
    step();
    chk("E_rst", {cfg_err, locked, tick, outclk}, 0);
    rst = 1;
    step();
    chk("E_resume", {tick, outclk}, 8'hFF);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) != 0);
      sync      = ($urandom_range(0, 119) == 0);
      cfg_valid = ($urandom_range(0, 59) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_div   = DIV_W'($urandom_range(0, 10));
      cfg_phase = DIV_W'($urandom_range(0, 12));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
